// File: rtl/mxbus_pkg.sv
// Shared types and default widths for the MX bus master front-end.
package mxbus_pkg;

    localparam int unsigned MXBUS_ADDR_W = 8;
    localparam int unsigned MXBUS_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mxbus_mst_state_e;

    typedef struct packed {
        logic                    we;
        logic [MXBUS_ADDR_W-1:0] addr;
        logic [MXBUS_DATA_W-1:0] wdata;
    } mxbus_req_t;

endpackage

// File: rtl/mxbus_timeout_ctr.sv
// Saturating wait counter; expired_c is high in the LIMIT-th enabled cycle after a clear.
module mxbus_timeout_ctr #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired_c = (count_q == CNT_W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mxbus_master.sv
// Single-outstanding MX bus master: one client request at a time onto the m0 read/write channels.
// Optional bounded completion wait with error response: define MXBUS_MASTER_TIMEOUT_EN.
module mxbus_master
    import mxbus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  m0_rd_txn_start,
    output logic [ADDR_WIDTH-1:0] m0_rd_addr,
    input  logic [DATA_WIDTH-1:0] m0_rd_data,
    input  logic                  m0_rd_ready,
    input  logic                  m0_rd_txn_ack,
    input  logic                  m0_rd_txn_cpl,
    output logic                  m0_wr_txn_start,
    output logic [ADDR_WIDTH-1:0] m0_wr_addr,
    output logic [DATA_WIDTH-1:0] m0_wr_data,
    input  logic                  m0_wr_ready,
    input  logic                  m0_wr_txn_ack,
    input  logic                  m0_wr_txn_cpl
);

    mxbus_mst_state_e      state_q, state_d;
    mxbus_req_t            req_q, req_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_c;
    logic                  sel_cpl_c;
    logic                  unused_ack_c;

    // Acknowledges are informational only; completion alone ends a wait.
    assign unused_ack_c = m0_rd_txn_ack ^ m0_wr_txn_ack;

    assign sel_cpl_c = req_q.we ? m0_wr_txn_cpl : m0_rd_txn_cpl;

    // Start follows the slave ready in the same cycle, so it cannot be a flop.
    assign m0_rd_txn_start = (state_q == ST_ISSUE) && !req_q.we && m0_rd_ready;
    assign m0_wr_txn_start = (state_q == ST_ISSUE) &&  req_q.we && m0_wr_ready;

`ifdef MXBUS_MASTER_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;
    logic tmo_expired_c;

    mxbus_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q != ST_WAIT),
        .en        (state_q == ST_WAIT),
        .expired_c (tmo_expired_c)
    );

    assign rsp_err = rsp_err_q;
`else
    logic [31:0] unused_timeout_c;
    assign unused_timeout_c = 32'(TIMEOUT_CYCLES);
    assign rsp_err          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MXBUS_MASTER_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_ready_q && req_valid) begin
                    req_d.we    = req_we;
                    req_d.addr  = MXBUS_ADDR_W'(req_addr);
                    req_d.wdata = MXBUS_DATA_W'(req_wdata);
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m0_rd_txn_start || m0_wr_txn_start) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion in the expiry cycle still gives a normal response.
                if (sel_cpl_c) begin
                    rsp_rdata_d = req_q.we ? '0 : m0_rd_data;
`ifdef MXBUS_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = ST_RESP;
                end
`ifdef MXBUS_MASTER_TIMEOUT_EN
                else if (tmo_expired_c) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_rdata_d = '0;
`ifdef MXBUS_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_c      = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        rd_addr_d   = (busy_c && !req_d.we) ? ADDR_WIDTH'(req_d.addr)  : '0;
        wr_addr_d   = (busy_c &&  req_d.we) ? ADDR_WIDTH'(req_d.addr)  : '0;
        wr_data_d   = (busy_c &&  req_d.we) ? DATA_WIDTH'(req_d.wdata) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef MXBUS_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef MXBUS_MASTER_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign m0_rd_addr = rd_addr_q;
    assign m0_wr_addr = wr_addr_q;
    assign m0_wr_data = wr_data_q;

endmodule

// File: tb/tb_mxbus_master.sv
// Directed bench for mxbus_master with a one-cycle behavioural MX slave and injectable completions.
module tb_mxbus_master;

    logic       clk;
    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic       m0_rd_txn_start, m0_rd_ready, m0_rd_txn_ack, m0_rd_txn_cpl;
    logic [7:0] m0_rd_addr, m0_rd_data;
    logic       m0_wr_txn_start, m0_wr_ready, m0_wr_txn_ack, m0_wr_txn_cpl;
    logic [7:0] m0_wr_addr, m0_wr_data;

    // slave model controls
    logic       slave_en, load_en;
    logic [7:0] load_addr, load_data;
    logic       rd_cpl_m, wr_cpl_m;
    logic [7:0] rd_data_m;
    logic       rd_cpl_force, wr_cpl_force;
    logic [7:0] rd_force_data;
    logic [7:0] mem [256];
    int         cyc;

    int n_cmp;
    int n_bad;

    mxbus_master dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .m0_rd_txn_start (m0_rd_txn_start),
        .m0_rd_addr      (m0_rd_addr),
        .m0_rd_data      (m0_rd_data),
        .m0_rd_ready     (m0_rd_ready),
        .m0_rd_txn_ack   (m0_rd_txn_ack),
        .m0_rd_txn_cpl   (m0_rd_txn_cpl),
        .m0_wr_txn_start (m0_wr_txn_start),
        .m0_wr_addr      (m0_wr_addr),
        .m0_wr_data      (m0_wr_data),
        .m0_wr_ready     (m0_wr_ready),
        .m0_wr_txn_ack   (m0_wr_txn_ack),
        .m0_wr_txn_cpl   (m0_wr_txn_cpl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle slave: completion in the cycle after the start pulse.
    always @(posedge clk) begin
        rd_cpl_m <= 1'b0;
        wr_cpl_m <= 1'b0;
        if (load_en) mem[load_addr] <= load_data;
        if (slave_en && m0_rd_txn_start) begin
            rd_cpl_m  <= 1'b1;
            rd_data_m <= mem[m0_rd_addr];
        end
        if (slave_en && m0_wr_txn_start) begin
            wr_cpl_m         <= 1'b1;
            mem[m0_wr_addr]  <= m0_wr_data;
        end
    end

    assign m0_rd_txn_cpl = rd_cpl_m | rd_cpl_force;
    assign m0_wr_txn_cpl = wr_cpl_m | wr_cpl_force;
    assign m0_rd_txn_ack = rd_cpl_m;
    assign m0_wr_txn_ack = wr_cpl_m;
    assign m0_rd_data    = rd_cpl_force ? rd_force_data : rd_data_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, m0_rd_txn_start, m0_rd_addr,
                    m0_wr_txn_start, m0_wr_addr, m0_wr_data});
    endfunction

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge one cycle after the response handshake.
    task automatic run_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           input int hold, input int exp_lat, input int exp_start_n,
                           output logic [7:0] rdata, output logic err, output int acc_cyc);
        int n, rd_n, wr_n, start_at;
        bit addr_bad, rr_bad, bp_bad;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_req", 64'(req_ready), 64'd1);
        acc_cyc   = cyc;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        n = 1; rd_n = 0; wr_n = 0; start_at = 0;
        addr_bad = 1'b0; rr_bad = 1'b0;
        while (!rsp_valid && n < 40) begin
            if (req_ready) rr_bad = 1'b1;
            if (m0_rd_txn_start || m0_wr_txn_start) begin
                if (start_at == 0) start_at = n;
                if (we && (m0_wr_addr !== addr || m0_wr_data !== wdata || m0_rd_addr !== 8'h00))
                    addr_bad = 1'b1;
                if (!we && (m0_rd_addr !== addr || m0_wr_addr !== 8'h00))
                    addr_bad = 1'b1;
            end
            if (m0_rd_txn_start) rd_n++;
            if (m0_wr_txn_start) wr_n++;
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        chk("rsp_latency", 64'(n), 64'(exp_lat));
        chk("start_cycle", 64'(start_at), 64'(exp_start_n));
        chk("rd_start_count", 64'(rd_n), we ? 64'd0 : 64'd1);
        chk("wr_start_count", 64'(wr_n), we ? 64'd1 : 64'd0);
        chk("m0_addr_data_at_start", 64'(addr_bad), 64'd0);
        chk("req_ready_low_in_flight", 64'(rr_bad), 64'd0);
        rdata  = rsp_rdata;
        err    = rsp_err;
        bp_bad = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err || req_ready ||
                m0_rd_txn_start || m0_wr_txn_start) bp_bad = 1'b1;
        end
        if (hold > 0) chk("backpressure_stable", 64'(bp_bad), 64'd0);
        accept_rsp();
        chk("post_rsp_handshake", 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] rd;
    logic       er;
    int         acc, prev_acc, n;
    bit         bad;

    initial begin
        // watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 8'h12, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 8'h40, 8'h3C, 8'h00};
        vecs[2] = '{1'b0, 8'h40, 8'h00, 8'h3C};
        vecs[3] = '{1'b1, 8'hFF, 8'h81, 8'h00};
        vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h81};
        vecs[5] = '{1'b1, 8'h00, 8'h7E, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h7E};
        vecs[7] = '{1'b0, 8'h12, 8'h00, 8'hA5};

        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; m0_rd_ready = 1'b1; m0_wr_ready = 1'b1;
        slave_en = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        rd_cpl_force = 1'b0; wr_cpl_force = 1'b0; rd_force_data = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_reset", 64'(req_ready), 64'd1);

        load_en = 1'b1; load_addr = 8'h12; load_data = 8'hA5;
        @(negedge clk);
        load_en = 1'b0;

        // Stray completions while idle are ignored.
        rd_cpl_force = 1'b1; wr_cpl_force = 1'b1; rd_force_data = 8'h77;
        @(negedge clk);
        rd_cpl_force = 1'b0; wr_cpl_force = 1'b0;
        @(negedge clk);
        chk("idle_cpl_ignored", 64'({rsp_valid, req_ready}), 64'b01);

        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, 3, 1, rd, er, acc);
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_err", i), 64'(er), 64'd0);
            if (i > 0) chk($sformatf("vec%0d_throughput", i), 64'(acc - prev_acc), 64'd4);
            prev_acc = acc;
        end

        // Response back-pressure for 5 cycles.
        run_txn(1'b0, 8'h40, 8'h00, 5, 3, 1, rd, er, acc);
        chk("bp_rdata", 64'(rd), 64'h3C);

        // Read channel not ready for 3 cycles after the request.
        m0_rd_ready = 1'b0;
        fork
            begin
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1 m0_rd_ready = 1'b1;
            end
            run_txn(1'b0, 8'h12, 8'h00, 0, 6, 4, rd, er, acc);
        join
        chk("notready_rdata", 64'(rd), 64'hA5);

        // Silent slave: wrong-channel completion is ignored.
        slave_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h55;
        @(negedge clk);
        req_valid = 1'b0;
        chk("silent_rd_start", 64'(m0_rd_txn_start), 64'd1);
        @(negedge clk);
        wr_cpl_force = 1'b1;
        @(negedge clk);
        wr_cpl_force = 1'b0;
        chk("wrong_channel_cpl", 64'(rsp_valid), 64'd0);
`ifdef MXBUS_MASTER_TIMEOUT_EN
        n = 3;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 64'(n), 64'd18);
        chk("timeout_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, 1'b1, 8'h00}));
        accept_rsp();
        rd_cpl_force = 1'b1; rd_force_data = 8'h99;
        @(negedge clk);
        rd_cpl_force = 1'b0;
        @(negedge clk);
        chk("late_cpl_ignored", 64'({rsp_valid, req_ready}), 64'b01);

        // Completion in the expiry cycle wins over the timeout.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h66;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (16) @(negedge clk);
        rd_cpl_force = 1'b1; rd_force_data = 8'h6E;
        @(negedge clk);
        rd_cpl_force = 1'b0;
        chk("expiry_cpl_wins", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, 1'b0, 8'h6E}));
        accept_rsp();
`else
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) bad = 1'b1;
        end
        chk("unbounded_wait", 64'(bad), 64'd0);
        rd_cpl_force = 1'b1; rd_force_data = 8'h9C;
        @(negedge clk);
        rd_cpl_force = 1'b0;
        chk("long_wait_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, 1'b0, 8'h9C}));
        accept_rsp();
`endif

        // Reset one cycle after the start abandons the transaction.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h33;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_case_start", 64'(m0_rd_txn_start), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_wait_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_midreset", 64'(req_ready), 64'd1);
        rd_cpl_force = 1'b1; rd_force_data = 8'h44;
        @(negedge clk);
        rd_cpl_force = 1'b0;
        chk("post_reset_cpl_ignored", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("post_reset_idle", 64'({rsp_valid, req_ready}), 64'b01);
        slave_en = 1'b1;
        run_txn(1'b0, 8'h12, 8'h00, 0, 3, 1, rd, er, acc);
        chk("after_reset_read", 64'({er, rd}), 64'({1'b0, 8'hA5}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
